// File: rtl/tdm_demux_1bit_if.sv
// Bus between the serial TDM link and tdm_demux_1bit.
//   master : serial source / channel consumer (drives din, din_valid, sync)
//   slave  : the demultiplexer (drives ch_data, ch_valid, frame_done,
//            sync_err, parity_err)
interface tdm_demux_1bit_if #(
  parameter int NUM_CH = 4,
  parameter int WORD_W = 8
);
  logic                     din;
  logic                     din_valid;
  logic                     sync;
  logic [NUM_CH*WORD_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;
  logic                     frame_done;
  logic                     sync_err;
  logic                     parity_err;

  modport master (
    output din, din_valid, sync,
    input  ch_data, ch_valid, frame_done, sync_err, parity_err
  );

  modport slave (
    input  din, din_valid, sync,
    output ch_data, ch_valid, frame_done, sync_err, parity_err
  );
endinterface

// File: rtl/tdm_demux_1bit.sv
// Receiving end of a 1-bit serial TDM link. A frame is NUM_CH slots of
// WORD_W bits, channel 0 first, MSB first within a slot, with sync high on
// frame bit 0. Completed slots land in ch_data and are flagged on ch_valid.
// Optional macro TDM_DEMUX_PARITY_EN: one trailing even-parity bit per frame;
// frame_done moves to the parity edge and parity_err flags a mismatch.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   bus.din         : serial bit, sampled when bus.din_valid=1
//   bus.sync        : frame marker, coincident with bit 0
//   bus.ch_data     : channel k at [k*WORD_W +: WORD_W]
//   bus.ch_valid    : one-cycle per-channel update strobe
//   bus.frame_done  : one-cycle full-frame strobe
//   bus.sync_err    : one-cycle framing violation strobe
//   bus.parity_err  : one-cycle parity mismatch strobe (0 without the macro)
module tdm_demux_1bit #(
  parameter int NUM_CH = 4,
  parameter int WORD_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  tdm_demux_1bit_if.slave  bus
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW = $clog2(WORD_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);

  typedef enum logic [1:0] {HUNT, RECV, PARITY} state_t;

  state_t                   r_state, w_nxt_state;
  logic [BW-1:0]            r_bit, w_nxt_bit;
  logic [CW-1:0]            r_ch, w_nxt_ch;
  logic [WORD_W-1:0]        r_shift, w_nxt_shift, w_shift_in;
  logic                     r_par, w_nxt_par;
  logic [NUM_CH*WORD_W-1:0] r_ch_data, w_nxt_ch_data;
  logic [NUM_CH-1:0]        r_ch_valid, w_nxt_ch_valid;
  logic                     r_frame_done, w_nxt_frame_done;
  logic                     r_sync_err, w_nxt_sync_err;
  logic                     r_parity_err, w_nxt_parity_err;
  logic                     w_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= HUNT;
      r_bit        <= '0;
      r_ch         <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_ch_data    <= '0;
      r_ch_valid   <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_bit        <= w_nxt_bit;
      r_ch         <= w_nxt_ch;
      r_shift      <= w_nxt_shift;
      r_par        <= w_nxt_par;
      r_ch_data    <= w_nxt_ch_data;
      r_ch_valid   <= w_nxt_ch_valid;
      r_frame_done <= w_nxt_frame_done;
      r_sync_err   <= w_nxt_sync_err;
      r_parity_err <= w_nxt_parity_err;
    end
  end

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_bit        = r_bit;
    w_nxt_ch         = r_ch;
    w_nxt_shift      = r_shift;
    w_nxt_par        = r_par;
    w_nxt_ch_data    = r_ch_data;
    w_nxt_ch_valid   = '0;
    w_nxt_frame_done = 1'b0;
    w_nxt_sync_err   = 1'b0;
    w_nxt_parity_err = 1'b0;
    w_start          = 1'b0;
    w_shift_in       = {r_shift[WORD_W-2:0], bus.din};

    if (bus.din_valid) begin
      unique case (r_state)
        HUNT: w_start = bus.sync;

        RECV: begin
          if (r_ch == '0 && r_bit == '0) begin
            // Frame boundary: sync must be present here.
            if (bus.sync) begin
              w_start = 1'b1;
            end else begin
              w_nxt_sync_err = 1'b1;
              w_nxt_state    = HUNT;
              w_nxt_shift    = '0;
              w_nxt_par      = 1'b0;
            end
          end else if (bus.sync) begin
            // Early sync: drop the partial word, restart on this bit.
            w_nxt_sync_err = 1'b1;
            w_start        = 1'b1;
          end else begin
            w_nxt_shift = w_shift_in;
            w_nxt_par   = r_par ^ bus.din;
            if (r_bit == LAST_BIT) begin
              w_nxt_ch_data[r_ch*WORD_W +: WORD_W] = w_shift_in;
              w_nxt_ch_valid[r_ch] = 1'b1;
              w_nxt_bit            = '0;
              if (r_ch == LAST_CH) begin
                w_nxt_ch = '0;
`ifdef TDM_DEMUX_PARITY_EN
                w_nxt_state = PARITY;
`else
                w_nxt_frame_done = 1'b1;
`endif
              end else begin
                w_nxt_ch = r_ch + CW'(1);
              end
            end else begin
              w_nxt_bit = r_bit + BW'(1);
            end
          end
        end

        PARITY: begin
          if (bus.sync) begin
            w_nxt_sync_err = 1'b1;
            w_start        = 1'b1;
          end else begin
            // Even parity: data XOR parity bit must be 0.
            if (r_par ^ bus.din) w_nxt_parity_err = 1'b1;
            else                 w_nxt_frame_done = 1'b1;
            w_nxt_state = RECV;
            w_nxt_par   = 1'b0;
          end
        end

        default: w_nxt_state = HUNT;
      endcase

      if (w_start) begin
        w_nxt_state = RECV;
        w_nxt_shift = {{(WORD_W-1){1'b0}}, bus.din};
        w_nxt_bit   = BW'(1);
        w_nxt_ch    = '0;
        w_nxt_par   = bus.din;
      end
    end
  end

  assign bus.ch_data    = r_ch_data;
  assign bus.ch_valid   = r_ch_valid;
  assign bus.frame_done = r_frame_done;
  assign bus.sync_err   = r_sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  assign bus.parity_err = r_parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_tdm_demux_1bit.sv
module tb_tdm_demux_1bit;
  localparam int NUM_CH = 4;
  localparam int WORD_W = 8;
  localparam int DBITS  = NUM_CH * WORD_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tdm_demux_1bit_if #(.NUM_CH(NUM_CH), .WORD_W(WORD_W)) bus ();
  tdm_demux_1bit #(.NUM_CH(NUM_CH), .WORD_W(WORD_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_chk = 0, n_err = 0;
  int cnt_fd = 0, cnt_se = 0, cnt_pe = 0, cnt_cv = 0;

  // Reference model: the bits of the current frame are kept in a queue;
  // slot words are rebuilt from the queue whenever a slot's worth arrives.
  bit              m_hunt = 1'b1;
  bit              m_bits[$];
  logic [DBITS-1:0] m_data = '0;
  logic [NUM_CH-1:0] e_cv;
  bit e_fd, e_se, e_pe;

  task automatic model(input bit d, input bit dv, input bit s, input bit r);
    int n, k, w;
    bit x;
    e_cv = '0; e_fd = 0; e_se = 0; e_pe = 0;
    if (r) begin m_hunt = 1; m_bits.delete(); m_data = '0; return; end
    if (!dv) return;
    if (m_hunt) begin
      if (s) begin m_hunt = 0; m_bits.delete(); m_bits.push_back(d); end
      return;
    end
    if (m_bits.size() == 0) begin
      if (s) m_bits.push_back(d);
      else begin e_se = 1; m_hunt = 1; end
      return;
    end
    if (s) begin e_se = 1; m_bits.delete(); m_bits.push_back(d); return; end
    m_bits.push_back(d);
    n = m_bits.size();
    if (n <= DBITS && n % WORD_W == 0) begin
      k = n / WORD_W - 1;
      w = 0;
      for (int i = n - WORD_W; i < n; i++) w = w * 2 + int'(m_bits[i]);
      m_data[k*WORD_W +: WORD_W] = WORD_W'(w);
      e_cv[k] = 1;
`ifndef TDM_DEMUX_PARITY_EN
      if (n == DBITS) begin e_fd = 1; m_bits.delete(); end
`endif
    end
`ifdef TDM_DEMUX_PARITY_EN
    if (n == DBITS + 1) begin
      x = 0;
      foreach (m_bits[i]) x ^= m_bits[i];
      if (x) e_pe = 1; else e_fd = 1;
      m_bits.delete();
    end
`endif
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive, clock, update model, sample 1 time unit later.
  task automatic step(input bit d, input bit dv, input bit s, input bit r);
    bus.din = d; bus.din_valid = dv; bus.sync = s; reset = r;
    @(posedge clk);
    model(d, dv, s, r);
    #1;
    chk("ch_data",    32'(bus.ch_data),    32'(m_data));
    chk("ch_valid",   32'(bus.ch_valid),   32'(e_cv));
    chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
    chk("sync_err",   32'(bus.sync_err),   32'(e_se));
    chk("parity_err", 32'(bus.parity_err), 32'(e_pe));
    if (bus.frame_done) cnt_fd++;
    if (bus.sync_err)   cnt_se++;
    if (bus.parity_err) cnt_pe++;
    if (bus.ch_valid != 0) cnt_cv++;
  endtask

  task automatic send_bits(input logic [DBITS-1:0] w, input int nb, input bit stall);
    int i;
    i = 0;
    for (int k = 0; k < NUM_CH; k++)
      for (int b = WORD_W - 1; b >= 0; b--) begin
        if (i < nb) begin
          step(w[k*WORD_W+b], 1'b1, (i == 0), 1'b0);
          if (stall) step(1'($urandom), 1'b0, 1'($urandom), 1'b0);
        end
        i++;
      end
  endtask

  task automatic send_frame(input logic [DBITS-1:0] w, input bit stall, input bit par_flip);
    send_bits(w, DBITS, stall);
`ifdef TDM_DEMUX_PARITY_EN
    step((^w) ^ par_flip, 1'b1, 1'b0, 1'b0);
    if (stall) step(1'b0, 1'b0, 1'b0, 1'b0);
`else
    if (par_flip) step(1'b0, 1'b0, 1'b0, 1'b0);
`endif
  endtask

  typedef struct {
    logic [DBITS-1:0] words;
    bit               stall;
    logic [DBITS-1:0] exp_data;
  } vec_t;
  vec_t tbl[4];

  initial begin
    int fd0, se0, cv0, pe0;
    bit d, dv, s, r;

    tbl[0] = '{32'h00FF3CA5, 1'b0, 32'h00FF3CA5};
    tbl[1] = '{32'h00FF3CA5, 1'b1, 32'h00FF3CA5};
    tbl[2] = '{32'h44332211, 1'b0, 32'h44332211};
    tbl[3] = '{32'hDEADBEEF, 1'b1, 32'hDEADBEEF};

    bus.din = 0; bus.din_valid = 0; bus.sync = 0;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("reset ch_data", 32'(bus.ch_data), 32'h0);

    // Back-to-back table frames, some with stalls.
    foreach (tbl[i]) begin
      fd0 = cnt_fd; se0 = cnt_se;
      send_frame(tbl[i].words, tbl[i].stall, 1'b0);
      chk($sformatf("vec%0d data", i), 32'(bus.ch_data), 32'(tbl[i].exp_data));
      chk($sformatf("vec%0d fd count", i), 32'(cnt_fd - fd0), 32'd1);
      chk($sformatf("vec%0d no sync_err", i), 32'(cnt_se - se0), 32'd0);
    end

    // Early sync at bit 12 of a frame whose ch0=A5.
    send_bits(32'h00FF3CA5, 12, 1'b0);
    chk("early ch0 kept", 32'(bus.ch_data[7:0]), 32'hA5);
    se0 = cnt_se; fd0 = cnt_fd;
    send_frame(32'h87654321, 1'b0, 1'b0);
    chk("early sync_err", 32'(cnt_se - se0), 32'd1);
    chk("early restart data", 32'(bus.ch_data), 32'h87654321);
    chk("early restart fd", 32'(cnt_fd - fd0), 32'd1);

    // Missing sync at a frame boundary, then HUNT ignores bits.
    step(1, 1, 0, 0);
    chk("missing sync_err", 32'(bus.sync_err), 32'd1);
    cv0 = cnt_cv; se0 = cnt_se;
    for (int i = 0; i < 20; i++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
    chk("hunt no ch_valid", 32'(cnt_cv - cv0), 32'd0);
    chk("hunt no sync_err", 32'(cnt_se - se0), 32'd0);
    send_frame(32'hCAFE0123, 1'b0, 1'b0);
    chk("post-hunt data", 32'(bus.ch_data), 32'hCAFE0123);

    // Reset on bit 20.
    send_bits(32'h13572468, 20, 1'b0);
    step(1, 1, 0, 1);
    chk("midreset ch_data", 32'(bus.ch_data), 32'h0);
    chk("midreset ch_valid", 32'(bus.ch_valid), 32'h0);
    send_frame(32'h0BADF00D, 1'b0, 1'b0);
    chk("post-reset data", 32'(bus.ch_data), 32'h0BADF00D);

`ifdef TDM_DEMUX_PARITY_EN
    fd0 = cnt_fd; pe0 = cnt_pe;
    send_frame(32'h00FF3CA5, 1'b0, 1'b1);
    chk("bad parity pe", 32'(cnt_pe - pe0), 32'd1);
    chk("bad parity fd", 32'(cnt_fd - fd0), 32'd0);
    chk("bad parity data", 32'(bus.ch_data), 32'h00FF3CA5);
`else
    pe0 = cnt_pe;
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      dv = ($urandom_range(0, 3) != 0);
      d  = 1'($urandom);
      if (m_hunt || m_bits.size() == 0) s = ($urandom_range(0, 19) != 0);
      else                              s = ($urandom_range(0, 49) == 0);
      r  = ($urandom_range(0, 599) == 0);
      step(d, dv, s, r);
    end
`ifndef TDM_DEMUX_PARITY_EN
    chk("parity_err never", 32'(cnt_pe - pe0), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
